// File: rtl/regfile_pkg.sv
// Shared register-file read path definitions: widths, register count and the
// read-arbiter FSM encoding, used by the shared read mux and its arbiter.
package regfile_pkg;

  localparam int SIZE       = 32;
  localparam int NUM_REG    = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'b00;
  localparam state_t DRIVE = 2'b01;
  localparam state_t RESP  = 2'b10;

  // Round-robin successor of a winning requester index among n requesters.
  function automatic int unsigned rr_next(input int unsigned winner, input int unsigned n);
    return (winner + 32'd1) % n;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Purely combinational round-robin selector: scans the request vector starting
// at ptr and returns a one-hot grant for the first active request found.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // First-hit scan in rotated order; later hits are masked once one is taken.
  always_comb begin
    logic             taken;
    logic [PTR_W-1:0] idx;
    grant = '0;
    taken = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx        = PTR_W'((int'(ptr) + off) % NUM_REQ);
      grant[idx] = req[idx] & ~taken;
      taken      = taken | req[idx];
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Arbitrates NUM_REQ requesters onto the shared register read mux: grant in IDLE,
// drive the mux for one cycle, then return the captured value with a one-cycle strobe.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int SIZE       = regfile_pkg::SIZE,
  parameter int NUM_REQ    = 4,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [REG_ADDR_W-1:0]         rd_select,
  output logic                          rd_enable,
  input  logic [SIZE-1:0]               rd_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [SIZE-1:0]               rsp_data,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_REQ = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [PTR_W-1:0]        rr_ptr_r;
  logic [PTR_W-1:0]        winner_r;
  logic [REG_ADDR_W-1:0]   rd_select_r;
  logic                    rd_enable_r;
  logic [NUM_REQ-1:0]      rsp_valid_r;
  logic [SIZE-1:0]         rsp_data_r;
  logic                    busy_r;

  logic [NUM_REQ-1:0]      grant_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic [PTR_W-1:0]        win_idx_s;
  logic [REG_ADDR_W-1:0]   win_addr_s;
  logic [NUM_REQ-1:0]      winner_onehot_s;
  logic                    hs_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  // Grant only in IDLE and never while reset is held; the winner's address is
  // picked from the packed bus only for use on the handshake edge.
  always_comb begin
    req_ready_s = '0;
    win_idx_s   = '0;
    win_addr_s  = '0;
    if ((state_r == IDLE) && rst_n) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      win_idx_s  = win_idx_s | (grant_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      win_addr_s = win_addr_s |
                   (grant_s[i] ? req_addr[i*REG_ADDR_W +: REG_ADDR_W] : {REG_ADDR_W{1'b0}});
    end
  end

  assign hs_s            = |(req_valid & req_ready_s);
  assign winner_onehot_s = ONE_REQ << winner_r;

  // Read-sequencing FSM with registered mux controls and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      winner_r    <= '0;
      rd_select_r <= '0;
      rd_enable_r <= 1'b0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= '0;
          if (hs_s) begin
            winner_r    <= win_idx_s;
            rd_select_r <= win_addr_s;
            rd_enable_r <= 1'b1;
            rr_ptr_r    <= PTR_W'(rr_next(32'(win_idx_s), 32'(NUM_REQ)));
            busy_r      <= 1'b1;
            state_r     <= DRIVE;
          end else begin
            rd_enable_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        DRIVE: begin
          rsp_data_r  <= rd_data;
          rsp_valid_r <= winner_onehot_s;
          rd_enable_r <= 1'b0;
          busy_r      <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          // Enable stays low here so consecutive grants always see a turnaround cycle.
          rsp_valid_r <= '0;
          rd_enable_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          rsp_valid_r <= '0;
          rd_enable_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rd_select = rd_select_r;
  assign rd_enable = rd_enable_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, register data width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing the read port.
REQ-003 The block SHALL have parameter REG_ADDR_W, default 5, register select width (32 registers).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid  input  NUM_REQ  per-requester read request.
REQ-007 The block SHALL have port req_addr  input  NUM_REQ*REG_ADDR_W  packed register addresses, requester i at bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-008 The block SHALL have port req_ready  output  NUM_REQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port rd_select  output  REG_ADDR_W  select to the shared 32:1 register read mux.
REQ-010 The block SHALL have port rd_enable  output  1  output-buffer enable of the shared read mux.
REQ-011 The block SHALL have port rd_data  input  SIZE  read-mux output.
REQ-012 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe.
REQ-013 The block SHALL have port rsp_data  output  SIZE  captured register value.
REQ-014 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE and RESP.
REQ-016 In IDLE with any req_valid high, req_ready SHALL be asserted combinationally for exactly one requester, chosen round-robin starting at pointer rr_ptr; otherwise req_ready SHALL be all zero.
REQ-017 req_ready SHALL be all zero in DRIVE and RESP.
REQ-018 On handshake, the winner index and its address SHALL be latched, rr_ptr SHALL become (winner+1) mod NUM_REQ, and the state SHALL go to DRIVE.
REQ-019 In DRIVE, rd_select SHALL equal the latched address and rd_enable SHALL be 1, both driven from registers (glitch-free).
REQ-020 At the end of DRIVE, rd_data SHALL be captured into rsp_data and the state SHALL go to RESP.
REQ-021 In RESP, rsp_valid[winner] SHALL be 1 for exactly one cycle, rd_enable SHALL be 0 (bus turnaround), and the state SHALL return to IDLE.
REQ-022 Latency SHALL be fixed: a handshake in cycle T gives rsp_valid in cycle T+2; maximum throughput SHALL be one grant per 3 cycles.
REQ-023 rsp_data SHALL hold its value until the next capture.
REQ-024 rd_select SHALL hold its last value outside DRIVE.
REQ-025 Requesters SHALL hold req_valid and req_addr stable until granted; the block SHALL NOT sample req_addr outside the handshake cycle.
REQ-026 With all requesters valid continuously, grants SHALL rotate with no requester starved beyond NUM_REQ-1 intervening grants.
REQ-027 A requester whose req_valid drops before grant SHALL be skipped, with no error raised.
REQ-028 All addresses 0..31 SHALL be legal; address 0 SHALL NOT be special-cased.
REQ-029 rd_enable SHALL never be high for two consecutive grants without an intervening low cycle.

Reset
REQ-030 While rst_n is low, the block SHALL hold: state IDLE, rr_ptr 0, req_ready 0, rd_enable 0, rd_select 0, rsp_valid 0, rsp_data 0, busy 0.
REQ-031 Reset asserted mid-operation SHALL drop the in-flight read silently; no rsp_valid SHALL follow the release of reset.
REQ-032 The first grant after reset SHALL go to the lowest-indexed valid requester.

Structure
REQ-033 Package regfile_pkg SHALL hold SIZE, NUM_REG (32), REG_ADDR_W and the FSM state enum; the shared mux and this block SHALL both use it.
REQ-034 The round-robin selector SHALL be a separate sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant), and it SHALL be purely combinational.

Verification
REQ-035 Single request: req_valid=4'b0001, addr 7, rd_data=32'hDEADBEEF in DRIVE -> rd_select=7 and rd_enable=1 at T+1; rsp_valid=4'b0001 and rsp_data=32'hDEADBEEF at T+2.
REQ-036 All four requesters valid continuously after reset -> grant order 0,1,2,3,0, with one grant every 3 cycles.
REQ-037 rr_ptr=2 with only requesters 0 and 3 valid -> requester 3 is granted first, then requester 0.
REQ-038 rst_n pulsed low during DRIVE -> rd_enable=0 immediately, and rsp_valid stays 0 for 5 cycles after release.
REQ-039 Requester 1 drops req_valid while requester 0 is being served -> the next grant goes to requester 2 (valid), and requester 1 receives no response.
REQ-040 Back-to-back reads of addr 0 then addr 31 -> rd_enable pattern 1,0,0,1 across the two transactions, and rsp_data values match the mux model.
